floor_request_scheduler: RTL and testbench

Collects hall/car button presses for each floor and holds them as pending requests. Drives the `floors_triggered` vector of the elevator controller. Watches the controller's `floor`/`direction` outputs and sequences the door-dwell at each served floor, clearing the served request once the dwell completes. Sits between the synchronized button inputs and the elevator controller.

---
 rtl/floor_request_scheduler.sv | 158 +++++++++++++++
 tb/tb_floor_request_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/floor_request_scheduler.sv
// Floor request scheduler: button capture, pending requests, door dwell.
// Optional REQ_CANCEL_EN adds a level-sensitive per-floor cancel input.
module floor_request_scheduler #(
    parameter int NUM_FLOORS  = 6,
    parameter int FLOOR_W     = 4,
    parameter int DWELL_TICKS = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  en,
    input  logic [NUM_FLOORS-1:0] buttons,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  direction,
`ifdef REQ_CANCEL_EN
    input  logic [NUM_FLOORS-1:0] cancel,
`endif
    output logic [NUM_FLOORS-1:0] floors_triggered,
    output logic                  door_open,
    output logic                  served_pulse,
    output logic [FLOOR_W-2:0]    served_floor
);

    localparam int IW = FLOOR_W - 1;
    localparam int CW = $clog2(DWELL_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARRIVE,
        S_DWELL,
        S_CLEAR
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_FLOORS-1:0] r_sync;
    logic [NUM_FLOORS-1:0] r_prev;
    logic [NUM_FLOORS-1:0] r_req;
    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [FLOOR_W-1:0]    r_pos;

    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_cancel;
    logic [NUM_FLOORS-1:0] w_sel;
    logic [NUM_FLOORS-1:0] w_dsel;
    logic [NUM_FLOORS-1:0] w_req_next;
    logic [IW-1:0]         w_idx;
    logic                  w_at;
    logic                  w_hit;
    logic                  w_drop;
    logic                  w_unused;

    assign w_unused = direction;

`ifdef REQ_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = '0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= buttons;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_set = r_sync[SYNC_STAGES-1] & ~r_prev;

    assign w_idx = floor[FLOOR_W-1:1];
    assign w_at  = ~floor[0] &&
                   ({1'b0, w_idx} < FLOOR_W'(NUM_FLOORS));

    always_comb begin
        w_sel  = '0;
        w_dsel = '0;
        w_clr  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_sel[i]  = w_at && (w_idx == IW'(i));
            w_dsel[i] = (r_idx == IW'(i));
            w_clr[i]  = (r_state == S_CLEAR) && w_dsel[i];
        end
    end

    // set beats the CLEAR of the same floor; cancel beats everything
    assign w_req_next = ((r_req & ~w_clr) | w_set) & ~w_cancel;

    assign w_hit  = |(r_req & w_sel);
    assign w_drop = ~(|(r_req & w_dsel)) | (|(w_cancel & w_dsel));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_req <= '0;
        end else begin
            r_req <= w_req_next;
        end
    end

    assign floors_triggered = r_req;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pos        <= '0;
            door_open    <= 1'b0;
            served_pulse <= 1'b0;
            served_floor <= '0;
        end else begin
            served_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_state <= S_ARRIVE;
                        r_idx   <= w_idx;
                        r_pos   <= floor;
                    end
                end
                S_ARRIVE: begin
                    door_open <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= S_DWELL;
                end
                S_DWELL: begin
                    if ((floor != r_pos) || w_drop) begin
                        r_state   <= S_IDLE;
                        door_open <= 1'b0;
                    end else if (en) begin
                        if (r_cnt == LAST) begin
                            r_state      <= S_CLEAR;
                            door_open    <= 1'b0;
                            served_pulse <= 1'b1;
                            served_floor <= r_idx;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_CLEAR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Scoreboard bench for floor_request_scheduler.
// Serve events queued by stimulus, checked by a pulse monitor.
module tb_floor_request_scheduler;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       en;
    logic [5:0] buttons;
    logic [3:0] floor;
    logic       direction;
    logic [5:0] floors_triggered;
    logic       door_open;
    logic       served_pulse;
    logic [2:0] served_floor;
`ifdef REQ_CANCEL_EN
    logic [5:0] cancel;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int d_cnt;
    int p_cnt;

    floor_request_scheduler dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .en               (en),
        .buttons          (buttons),
        .floor            (floor),
        .direction        (direction),
`ifdef REQ_CANCEL_EN
        .cancel           (cancel),
`endif
        .floors_triggered (floors_triggered),
        .door_open        (door_open),
        .served_pulse     (served_pulse),
        .served_floor     (served_floor)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", nm, act, exp);
        end
    endtask

    task automatic press(input int b);
        buttons[b] = 1'b1;
        tick(3);
        buttons[b] = 1'b0;
        tick(2);
    endtask

    task automatic window(input int n, output int d, output int p);
        d = 0;
        p = 0;
        repeat (n) begin
            tick(1);
            if (door_open) d++;
            if (served_pulse) p++;
        end
    endtask

    always @(negedge clk) begin
        if (n_rst === 1'b1 && served_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_serve: got pulse for floor %0d, required none",
                         served_floor);
            end else begin
                chk("served_floor", int'(served_floor), exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst     = 1'b0;
        en        = 1'b0;
        buttons   = 6'h3F;
        floor     = 4'd14;
        direction = 1'b1;
`ifdef REQ_CANCEL_EN
        cancel    = 6'h00;
`endif
        tick(4);
        chk("rst_ft", int'(floors_triggered), 'h00);
        chk("rst_door", int'(door_open), 0);
        chk("rst_pulse", int'(served_pulse), 0);
        chk("rst_sfloor", int'(served_floor), 0);

        n_rst = 1'b1;
        tick(2);
        chk("sync_early", int'(floors_triggered), 'h00);
        tick(1);
        chk("sync_all", int'(floors_triggered), 'h3F);
        tick(6);
        chk("oor_no_door", int'(door_open), 0);

        n_rst = 1'b0;
        #1;
        chk("async_drop", int'(floors_triggered), 'h00);
        buttons = 6'h00;
        tick(2);
        n_rst = 1'b1;
        tick(3);

        press(2);
        chk("req_2", int'(floors_triggered), 'h04);
        exp_q.push_back(2);
        en    = 1'b1;
        floor = 4'd4;
        window(12, d_cnt, p_cnt);
        chk("serve_door_cycles", d_cnt, 5);
        chk("serve_pulse_cycles", p_cnt, 1);
        chk("serve_ft", int'(floors_triggered), 'h00);
        floor = 4'd14;

        press(1);
        floor = 4'd3;
        window(10, d_cnt, p_cnt);
        chk("odd_door_cycles", d_cnt, 0);
        chk("odd_ft", int'(floors_triggered), 'h02);

        exp_q.push_back(1);
        exp_q.push_back(1);
        floor = 4'd2;
        tick(5);
        buttons[1] = 1'b1;
        tick(3);
        chk("simul_keep", int'(floors_triggered), 'h02);
        tick(2);
        chk("simul_redwell", int'(door_open), 1);
        buttons[1] = 1'b0;
        tick(10);
        chk("simul_ft", int'(floors_triggered), 'h00);
        floor = 4'd14;

        press(3);
        chk("req_3", int'(floors_triggered), 'h08);
        en    = 1'b0;
        floor = 4'd6;
        tick(10);
        chk("freeze_door", int'(door_open), 1);
        exp_q.push_back(3);
        en = 1'b1;
        tick(8);
        chk("freeze_ft", int'(floors_triggered), 'h00);
        chk("freeze_door_off", int'(door_open), 0);
        floor = 4'd14;

        press(4);
        floor = 4'd8;
        tick(3);
        chk("abort_door_on", int'(door_open), 1);
        floor = 4'd9;
        tick(1);
        chk("abort_door_off", int'(door_open), 0);
        chk("abort_ft", int'(floors_triggered), 'h10);
        tick(6);
        floor = 4'd14;

`ifdef REQ_CANCEL_EN
        press(0);
        press(5);
        chk("cxl_pre", int'(floors_triggered), 'h31);
        cancel = 6'b100000;
        tick(1);
        cancel = 6'h00;
        chk("cxl_ft", int'(floors_triggered), 'h11);
        floor = 4'd0;
        tick(3);
        chk("cxl_door_on", int'(door_open), 1);
        cancel = 6'b000001;
        tick(1);
        cancel = 6'h00;
        chk("cxl_door_off", int'(door_open), 0);
        chk("cxl_dwell_ft", int'(floors_triggered), 'h10);
        tick(6);
        floor = 4'd14;
`endif

        tick(2);
        chk("last_sfloor", int'(served_floor), 3);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
